// File: rtl/ttni_flit_pkg.sv
// Shared flit encoding, header field widths and sink state set for the TTNI gateway.
package ttni_flit_pkg;

   localparam int TRAFFIC_ID_W = 4;
   localparam int OPCODE_W     = 28;
   localparam int DEST_PORT_W  = 8;
   localparam int GTB_W        = 32;
   localparam int LEN_W        = 11;
   localparam int CSR_LEN      = 40;

   typedef enum logic [1:0] {
      BODY = 2'b00,
      HEAD = 2'b01,
      TAIL = 2'b10,
      RSVD = 2'b11
   } flit_type_e;

   typedef enum logic [2:0] {
      IDLE,
      PORT,
      TIME,
      PAYLD,
      HOLD
   } sink_state_e;

endpackage

// File: rtl/sink_fsm_flit_type_decode.sv
// Splits a {type,data} flit into one-hot type flags and the data word.
module flit_type_decode
   import ttni_flit_pkg::*;
#(
   parameter int DW = 32,
   parameter int TW = 2,
   parameter int FW = 34
) (
   input  logic [FW-1:0] flit,
   output logic          is_head,
   output logic          is_body,
   output logic          is_tail,
   output logic          is_rsvd,
   output logic [DW-1:0] data
);

   flit_type_e ftype;

   always_comb begin
      ftype   = flit_type_e'(flit[FW-1 -: TW]);
      data    = flit[DW-1:0];
      is_head = (ftype == HEAD);
      is_body = (ftype == BODY);
      is_tail = (ftype == TAIL);
      is_rsvd = (ftype == RSVD);
   end

endmodule

// File: rtl/sink_fsm.sv
// Destination-side TTNI sink: decodes the flit stream, writes payload after the CSR region
// and presents a message descriptor. Optional length check: define SINK_LEN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a header flit
// PORT  | header taken, next body flit carries dest_port_id
// TIME  | dest taken, next body flit carries the GTB timestamp
// PAYLD | writing payload words until the tail
// HOLD  | descriptor valid, waiting for msg_ack
module sink_fsm
   import ttni_flit_pkg::*;
#(
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int FLIT_TYPE_WIDTH = 2,
   parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
   parameter int VCHANNELS       = 1,
   parameter int MSG_LEN         = 1024,
   parameter int BASE_ADDR       = CSR_LEN,
   parameter int ADDR_W          = 11
) (
   input  logic                    clk,
   input  logic                    rst_sink_n,
   input  logic [FLIT_WIDTH-1:0]   flit_in,
   input  logic [VCHANNELS-1:0]    valid_in,
   output logic [VCHANNELS-1:0]    ready_out,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [31:0]             wr_data,
   output logic                    msg_valid,
   input  logic                    msg_ack,
   output logic [TRAFFIC_ID_W-1:0] rx_traffic_id,
   output logic [OPCODE_W-1:0]     rx_routing_opcode,
   output logic [DEST_PORT_W-1:0]  rx_dest_port_id,
   output logic [GTB_W-1:0]        rx_gtb,
   output logic [LEN_W-1:0]        rx_payload_len,
   input  logic [9:0]              exp_msglen,
   output logic                    err_proto,
   output logic                    err_ovf,
   output logic                    err_len
);

   logic                       f_head, f_body, f_tail, f_rsvd;
   logic [FLIT_DATA_WIDTH-1:0] f_data;

   flit_type_decode #(
      .DW (FLIT_DATA_WIDTH),
      .TW (FLIT_TYPE_WIDTH),
      .FW (FLIT_WIDTH)
   ) u_decode (
      .flit    (flit_in),
      .is_head (f_head),
      .is_body (f_body),
      .is_tail (f_tail),
      .is_rsvd (f_rsvd),
      .data    (f_data)
   );

   sink_state_e             state_q, state_d;
   logic                    ready_q, ready_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
   logic [31:0]             wr_data_q, wr_data_d;
   logic                    msg_valid_q, msg_valid_d;
   logic [TRAFFIC_ID_W-1:0] tid_q, tid_d;
   logic [OPCODE_W-1:0]     opc_q, opc_d;
   logic [DEST_PORT_W-1:0]  dest_q, dest_d;
   logic [GTB_W-1:0]        gtb_q, gtb_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic                    proto_q, proto_d;
   logic                    ovf_q, ovf_d;
   logic                    acc, load_hdr, do_write;
`ifdef SINK_LEN_CHECK_EN
   logic [9:0]              exp_q, exp_d;
   logic                    len_q, len_d;
`else
   logic                    unused_exp;
   assign unused_exp = ^exp_msglen;
`endif

   // ready is a flop of "next state != HOLD", so it never depends on valid_in
   assign acc = valid_in[0] && ready_q;

   always_comb begin
      state_d   = state_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      tid_d     = tid_q;
      opc_d     = opc_q;
      dest_d    = dest_q;
      gtb_d     = gtb_q;
      cnt_d     = cnt_q;
      proto_d   = 1'b0;
      ovf_d     = ovf_q;
      load_hdr  = 1'b0;
      do_write  = 1'b0;
`ifdef SINK_LEN_CHECK_EN
      exp_d     = exp_q;
`endif

      case (state_q)
         IDLE: begin
            if (acc) begin
               if (f_head) load_hdr = 1'b1;
               else        proto_d  = 1'b1;
            end
         end
         PORT: begin
            if (acc) begin
               if (f_head) begin
                  load_hdr = 1'b1;
                  proto_d  = 1'b1;
               end else if (f_body) begin
                  dest_d  = f_data[DEST_PORT_W-1:0];
                  state_d = TIME;
               end else if (f_tail) begin
                  proto_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  proto_d = 1'b1;
               end
            end
         end
         TIME: begin
            if (acc) begin
               if (f_head) begin
                  load_hdr = 1'b1;
                  proto_d  = 1'b1;
               end else if (f_body) begin
                  gtb_d   = f_data[GTB_W-1:0];
                  state_d = PAYLD;
               end else if (f_tail) begin
                  proto_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  proto_d = 1'b1;
               end
            end
         end
         PAYLD: begin
            if (acc) begin
               if (f_head) begin
                  load_hdr = 1'b1;
                  proto_d  = 1'b1;
               end else if (f_body) begin
                  do_write = 1'b1;
               end else if (f_tail) begin
                  do_write = 1'b1;
                  state_d  = HOLD;
               end else begin
                  proto_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (msg_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (load_hdr) begin
         tid_d   = f_data[31:28];
         opc_d   = f_data[OPCODE_W-1:0];
         cnt_d   = '0;
         ovf_d   = 1'b0;
         state_d = PORT;
`ifdef SINK_LEN_CHECK_EN
         exp_d   = exp_msglen;
`endif
      end

      // once the count saturates, extra words are dropped rather than wrapping
      if (do_write) begin
         if (cnt_q < LEN_W'(MSG_LEN)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q);
            wr_data_d = f_data[31:0];
            cnt_d     = cnt_q + LEN_W'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end

      msg_valid_d = (state_d == HOLD);
      ready_d     = (state_d != HOLD);

`ifdef SINK_LEN_CHECK_EN
      if (state_d == HOLD && state_q != HOLD)
         len_d = (cnt_d != (LEN_W'(exp_q) + LEN_W'(1)));
      else if (state_d != HOLD)
         len_d = 1'b0;
      else
         len_d = len_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_sink_n) begin
      if (!rst_sink_n) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         msg_valid_q <= 1'b0;
         tid_q       <= '0;
         opc_q       <= '0;
         dest_q      <= '0;
         gtb_q       <= '0;
         cnt_q       <= '0;
         proto_q     <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef SINK_LEN_CHECK_EN
         exp_q       <= '0;
         len_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         msg_valid_q <= msg_valid_d;
         tid_q       <= tid_d;
         opc_q       <= opc_d;
         dest_q      <= dest_d;
         gtb_q       <= gtb_d;
         cnt_q       <= cnt_d;
         proto_q     <= proto_d;
         ovf_q       <= ovf_d;
`ifdef SINK_LEN_CHECK_EN
         exp_q       <= exp_d;
         len_q       <= len_d;
`endif
      end
   end

   always_comb begin
      ready_out    = '0;
      ready_out[0] = ready_q;
   end

   assign wr_en             = wr_en_q;
   assign wr_addr           = wr_addr_q;
   assign wr_data           = wr_data_q;
   assign msg_valid         = msg_valid_q;
   assign rx_traffic_id     = tid_q;
   assign rx_routing_opcode = opc_q;
   assign rx_dest_port_id   = dest_q;
   assign rx_gtb            = gtb_q;
   assign rx_payload_len    = cnt_q;
   assign err_proto         = proto_q;
   assign err_ovf           = ovf_q;
`ifdef SINK_LEN_CHECK_EN
   assign err_len           = len_q;
`else
   assign err_len           = 1'b0;
`endif

endmodule

// File: tb/tb_sink_fsm.sv
// Randomized scoreboard bench for sink_fsm: driver pushes expected writes/descriptors,
// a negedge monitor pops and compares. Honours SINK_LEN_CHECK_EN when defined.
module tb_sink_fsm;

   localparam int MSG_LEN = 8;
   localparam int BASE    = 40;
   localparam logic [1:0] T_BODY = 2'b00;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;
   localparam logic [1:0] T_RSVD = 2'b11;

   logic        clk = 1'b0;
   logic        rst_sink_n = 1'b0;
   logic [33:0] flit_in = '0;
   logic [0:0]  valid_in = '0;
   logic [0:0]  ready_out;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [31:0] wr_data;
   logic        msg_valid;
   logic        msg_ack = 1'b0;
   logic [3:0]  rx_traffic_id;
   logic [27:0] rx_routing_opcode;
   logic [7:0]  rx_dest_port_id;
   logic [31:0] rx_gtb;
   logic [10:0] rx_payload_len;
   logic [9:0]  exp_msglen = '0;
   logic        err_proto, err_ovf, err_len;

   sink_fsm #(.MSG_LEN(MSG_LEN), .BASE_ADDR(BASE), .ADDR_W(11)) dut (
      .clk               (clk),
      .rst_sink_n        (rst_sink_n),
      .flit_in           (flit_in),
      .valid_in          (valid_in),
      .ready_out         (ready_out),
      .wr_en             (wr_en),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .msg_valid         (msg_valid),
      .msg_ack           (msg_ack),
      .rx_traffic_id     (rx_traffic_id),
      .rx_routing_opcode (rx_routing_opcode),
      .rx_dest_port_id   (rx_dest_port_id),
      .rx_gtb            (rx_gtb),
      .rx_payload_len    (rx_payload_len),
      .exp_msglen        (exp_msglen),
      .err_proto         (err_proto),
      .err_ovf           (err_ovf),
      .err_len           (err_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [3:0]  tid;
      logic [27:0] opc;
      logic [7:0]  dest;
      logic [31:0] gtb;
      logic [10:0] len;
      logic        ovf;
      logic        elen;
   } desc_t;

   wr_t   wq[$];
   desc_t dq[$];
   int    errors = 0;
   int    checks = 0;
   int    proto_exp = 0;
   int    proto_obs = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one flit and return just after the posedge that accepts it.
   task automatic send(input logic [1:0] t, input logic [31:0] d);
      bit r;
      bit done;
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      flit_in  = {t, d};
      valid_in = 1'b1;
      done     = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         r = ready_out[0];
         @(posedge clk);
         if (r) done = 1'b1;
         else   @(negedge clk);
      end
      #1 valid_in = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
      end
   endtask

   // Reference: first min(n,MSG_LEN) words land at BASE+i, the rest are dropped.
   task automatic run_msg(input logic [3:0] tid, input logic [27:0] opc, input logic [7:0] dest,
                          input logic [31:0] gtb, input int n, input int ex,
                          input bit restart, input bit rsvd_inj);
      logic [31:0] w;
      desc_t       d;
      exp_msglen = 10'(ex);
      if (restart) begin
         w = $urandom;
         send(T_HEAD, w);
         send(T_HEAD, {tid, opc});
         proto_exp++;
      end else begin
         send(T_HEAD, {tid, opc});
      end
      w = $urandom;
      send(T_BODY, {w[31:8], dest});
      send(T_BODY, gtb);
      if (rsvd_inj) begin
         w = $urandom;
         send(T_RSVD, w);
         proto_exp++;
      end
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         send((i == n - 1) ? T_TAIL : T_BODY, w);
         if (i < MSG_LEN) wq.push_back('{addr: 11'(BASE + i), data: w});
      end
      d.tid  = tid;
      d.opc  = opc;
      d.dest = dest;
      d.gtb  = gtb;
      d.len  = 11'((n < MSG_LEN) ? n : MSG_LEN);
      d.ovf  = (n > MSG_LEN);
`ifdef SINK_LEN_CHECK_EN
      d.elen = (int'(d.len) != ex + 1);
`else
      d.elen = 1'b0;
`endif
      dq.push_back(d);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((wq.size() != 0 || dq.size() != 0 || msg_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got wq=%0d dq=%0d expected empty", wq.size(), dq.size());
      end
   endtask

   // Monitor
   desc_t cur;
   bit    desc_active = 1'b0;

   always @(negedge clk) begin
      if (rst_sink_n) begin
         if (wr_en) begin
            if (wq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr=%0d expected no write", wr_addr);
            end else begin
               wr_t e;
               e = wq.pop_front();
               chk("wr_addr", 64'(wr_addr), 64'(e.addr));
               chk("wr_data", 64'(wr_data), 64'(e.data));
            end
         end
         if (err_proto) begin
            proto_obs++;
            chk("proto_pulse_expected", 64'(proto_obs <= proto_exp), 64'(1));
         end
         if (msg_valid) begin
            if (!desc_active) begin
               if (dq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_msg_valid: got 1 expected 0");
               end else begin
                  cur = dq.pop_front();
                  desc_active = 1'b1;
                  chk("rx_traffic_id", 64'(rx_traffic_id), 64'(cur.tid));
                  chk("rx_routing_opcode", 64'(rx_routing_opcode), 64'(cur.opc));
                  chk("rx_dest_port_id", 64'(rx_dest_port_id), 64'(cur.dest));
                  chk("rx_gtb", 64'(rx_gtb), 64'(cur.gtb));
                  chk("rx_payload_len", 64'(rx_payload_len), 64'(cur.len));
                  chk("err_ovf", 64'(err_ovf), 64'(cur.ovf));
                  chk("err_len", 64'(err_len), 64'(cur.elen));
               end
            end else begin
               chk("hold_len_stable", 64'(rx_payload_len), 64'(cur.len));
               chk("hold_gtb_stable", 64'(rx_gtb), 64'(cur.gtb));
               chk("hold_err_len", 64'(err_len), 64'(cur.elen));
            end
            chk("ready_in_hold", 64'(ready_out[0]), 64'(0));
         end else begin
            desc_active = 1'b0;
         end
      end
   end

   // Consumer: acks descriptors after a random delay, sometimes acks spuriously
   initial begin
      forever begin
         @(negedge clk);
         if (msg_valid) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            msg_ack = 1'b1;
            @(negedge clk);
            msg_ack = 1'b0;
         end else if (rst_sink_n && $urandom_range(0, 7) == 0) begin
            msg_ack = 1'b1;
            @(negedge clk);
            msg_ack = 1'b0;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, 64'(ready_out), 64'(0));
      chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
      chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
      chk({tag, "_msg_valid"}, 64'(msg_valid), 64'(0));
      chk({tag, "_tid"}, 64'(rx_traffic_id), 64'(0));
      chk({tag, "_gtb"}, 64'(rx_gtb), 64'(0));
      chk({tag, "_len"}, 64'(rx_payload_len), 64'(0));
      chk({tag, "_err"}, 64'({err_proto, err_ovf, err_len}), 64'(0));
   endtask

   initial begin
      logic [31:0] r1, r2;
      int          n, ex;

      #3;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_sink_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("ready_after_reset", 64'(ready_out[0]), 64'(1));

      // basic message
      run_msg(4'h3, 28'h0ABCDEF, 8'h05, 32'h1234, 4, 3, 1'b0, 1'b0);
      wait_drain();
      @(negedge clk);
      chk("ready_after_ack", 64'(ready_out[0]), 64'(1));

      // body in IDLE, then tail straight after the port flit
      send(T_BODY, 32'hDEAD_0001);
      proto_exp++;
      send(T_HEAD, {4'h1, 28'h1});
      send(T_BODY, 32'h0000_0007);
      send(T_TAIL, 32'hDEAD_0002);
      proto_exp++;
      repeat (3) @(negedge clk);
      chk("abort_no_msg_valid", 64'(msg_valid), 64'(0));
      chk("abort_ready", 64'(ready_out[0]), 64'(1));

      // overflow
      run_msg(4'h9, 28'h7654321, 8'hA0, 32'hCAFE_F00D, MSG_LEN + 2, MSG_LEN + 1, 1'b0, 1'b0);
      wait_drain();

      // length-check cases
      run_msg(4'h2, 28'h22, 8'h22, 32'h22, 4, 2, 1'b0, 1'b0);
      run_msg(4'h4, 28'h44, 8'h44, 32'h44, 3, 2, 1'b0, 1'b0);
      wait_drain();

      // async reset mid-payload
      r1 = $urandom;
      send(T_HEAD, {4'h5, 28'h55});
      send(T_BODY, 32'h11);
      send(T_BODY, 32'h22);
      r2 = $urandom;
      send(T_BODY, r2);
      wq.push_back('{addr: 11'(BASE), data: r2});
      send(T_BODY, r1);
      wq.push_back('{addr: 11'(BASE + 1), data: r1});
      @(negedge clk);
      @(negedge clk);
      #2 rst_sink_n = 1'b0;
      #1 check_all_zero("midreset");
      repeat (2) @(negedge clk);
      rst_sink_n = 1'b1;
      repeat (2) @(negedge clk);
      run_msg(4'h6, 28'h66, 8'h66, 32'h66, 2, 1, 1'b0, 1'b0);
      wait_drain();

      // randomized traffic
      for (int m = 0; m < 30; m++) begin
         if ($urandom_range(0, 5) == 0) begin
            r1 = $urandom;
            send(T_BODY, r1);
            proto_exp++;
         end
         if ($urandom_range(0, 5) == 0) begin
            r1 = $urandom;
            send(T_HEAD, r1);
            r1 = $urandom;
            send(T_TAIL, r1);
            proto_exp++;
         end
         if ($urandom_range(0, 4) == 0) n = MSG_LEN + $urandom_range(1, 3);
         else                           n = $urandom_range(1, MSG_LEN - 1);
         ex = ($urandom_range(0, 1) == 0) ? n - 1 : $urandom_range(0, 12);
         r1 = $urandom;
         r2 = $urandom;
         run_msg(r1[31:28], r1[27:0], r2[7:0], $urandom, n, ex,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      end
      wait_drain();
      repeat (3) @(negedge clk);

      chk("proto_count", 64'(proto_obs), 64'(proto_exp));
      chk("wq_empty", 64'(wq.size()), 64'(0));
      chk("dq_empty", 64'(dq.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish before 2ms");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

endmodule
